gt_refill_ctrl: RTL

Miss/refill sequencer for the direct-mapped byte-read cache (32-bit address, 256-bit lines, 8-bit read data).
- Accepts one CPU read at a time and looks it up in the cache.
- On a miss, writes back a dirty victim line, fetches the missing line from memory and fills the cache.
- Replays the lookup so the response always comes from the cache.
- Sits between the CPU request port, the cache array and the memory line interface.

---
 rtl/gt_cache_pkg.sv | 32 +++
 rtl/gt_refill_timer.sv | 43 ++++
 rtl/gt_refill_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gt_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gt_cache_pkg
// Description : Shared types, widths and helpers for the byte-read cache
//               miss/refill sequencer (gt_refill_ctrl and its timer).
//               Contents: ADDR_W, LINE_W, DATA_W, OFFSET_W, state_t and
//               line_align().
// Revision    : 1.0 - initial release
// ============================================================================
package gt_cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int DATA_W   = 8;
    localparam int OFFSET_W = 5;   // log2(LINE_W/8)

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WB_REQ    = 3'd2,
        ST_FETCH_REQ = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_FILL      = 3'd5
    } state_t;

    // Zero the byte-offset bits so the address points at the start of a line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gt_refill_timer.sv
`default_nettype none
// ============================================================================
// Module      : gt_refill_timer
// Description : Wait-for-memory-data timeout counter.
//   clk     in  clock
//   rst_n   in  synchronous active-low reset (count -> 0)
//   clear   in  restart the count at 0
//   enable  in  one more cycle spent waiting
//   expired out this enabled cycle brings the count to TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module gt_refill_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Flagged one cycle early so the controller can react on the same edge
    // the count reaches TIMEOUT.
    assign expired = enable && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/gt_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gt_refill_ctrl
// Description : Miss/refill sequencer for a direct-mapped byte-read cache.
//               Accepts one CPU read, looks it up, writes back a dirty
//               victim, fetches and fills the missing line, then replays the
//               lookup so every response comes from the cache.
//   CPU   : req_valid/req_addr/req_ready, resp_valid/resp_data
//   Cache : cache_addr, cache_hit, cache_dirty, cache_victim_addr,
//           cache_rdata, cache_wb_data, cache_fill_en, cache_fill_data
//   Memory: mem_req_valid/we/addr, mem_wdata, mem_req_ready,
//           mem_rdata_valid, mem_rdata
//   Status: timeout_err (one-cycle pulse when a fetch is reissued)
//   Optional macro GT_REFILL_PERF_CNT_EN adds saturating hit_cnt/miss_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module gt_refill_ctrl
    import gt_cache_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_hit,
    input  logic              cache_dirty,
    input  logic [ADDR_W-1:0] cache_victim_addr,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic [LINE_W-1:0] cache_wb_data,
    output logic              cache_fill_en,
    output logic [LINE_W-1:0] cache_fill_data,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_rdata_valid,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              timeout_err
`ifdef GT_REFILL_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_replay;     // current LOOKUP follows a fill
    logic              w_tmr_clear;
    logic              w_tmr_en;
    logic              w_tmr_expired;

    // The cache is always indexed by the captured request address; it is
    // only meaningful in LOOKUP and FILL.
    assign cache_addr  = r_addr;

    assign w_tmr_clear = (r_state == ST_FETCH_REQ) && mem_req_ready;
    assign w_tmr_en    = (r_state == ST_WAIT_DATA) && !mem_rdata_valid;

    gt_refill_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (w_tmr_clear),
        .enable  (w_tmr_en),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_replay        <= 1'b0;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            cache_fill_en   <= 1'b0;
            cache_fill_data <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_we      <= 1'b0;
            mem_req_addr    <= '0;
            mem_wdata       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            // Single-cycle strobes
            resp_valid    <= 1'b0;
            cache_fill_en <= 1'b0;
            timeout_err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr    <= req_addr;
                        r_replay  <= 1'b0;
                        req_ready <= 1'b0;
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cache_hit) begin
                        resp_valid <= 1'b1;
                        resp_data  <= cache_rdata;
                        req_ready  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (cache_dirty) begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b1;
                        mem_req_addr  <= line_align(cache_victim_addr);
                        mem_wdata     <= cache_wb_data;
                        r_state       <= ST_WB_REQ;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= line_align(r_addr);
                        r_state       <= ST_FETCH_REQ;
                    end
                end
                ST_WB_REQ: begin
                    // Writeback accepted: turn straight into the fetch
                    // request so mem_req_valid never gaps.
                    if (mem_req_ready) begin
                        mem_req_we   <= 1'b0;
                        mem_req_addr <= line_align(r_addr);
                        r_state      <= ST_FETCH_REQ;
                    end
                end
                ST_FETCH_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    // Data takes priority over a coincident timeout.
                    if (mem_rdata_valid) begin
                        cache_fill_data <= mem_rdata;
                        cache_fill_en   <= 1'b1;
                        r_replay        <= 1'b1;
                        r_state         <= ST_FILL;
                    end else if (w_tmr_expired) begin
                        timeout_err   <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= line_align(r_addr);
                        r_state       <= ST_FETCH_REQ;
                    end
                end
                ST_FILL: begin
                    r_state <= ST_LOOKUP;
                end
                default: begin
                    req_ready     <= 1'b1;
                    mem_req_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GT_REFILL_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (cache_hit && !r_replay && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (!cache_hit && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
